timer_ctrl: RTL and testbench

Control and sequencing unit for the countdown timer datapath. It turns edge-detected button pulses into preset editing (minutes/seconds), start/pause/clear sequencing, per-second decrement strobes and an alarm phase. It drives the minutes/seconds counter through `load`/`dec` and the 7-segment driver through blink masks. The tick input comes from the system clock divider; all logic runs on `clock`.

---
 rtl/timer_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_timer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Control and sequencing for the countdown timer: preset editing, start/pause,
// per-second decrement strobes for the datapath and the timed alarm phase.
module timer_ctrl #(
  parameter int unsigned MAX_MIN    = 59,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       tick_half,
  input  logic       cnt_zero,
  output logic       load,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       dec,
  output logic       alarm,
  output logic       blink_min,
  output logic       blink_sec,
  output logic [2:0] state
);

  localparam int unsigned FIELD_W = 6;
  localparam int unsigned ACNT_W  = $clog2(2 * ALARM_SECS + 1);

  localparam logic [FIELD_W-1:0] MIN_TOP   = FIELD_W'(MAX_MIN);
  localparam logic [FIELD_W-1:0] SEC_TOP   = FIELD_W'(59);
  localparam logic [ACNT_W-1:0]  ACNT_LAST = ACNT_W'(2 * ALARM_SECS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_MIN = 3'd1,
    S_SET_SEC = 3'd2,
    S_RUN     = 3'd3,
    S_PAUSE   = 3'd4,
    S_ALARM   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [FIELD_W-1:0] set_min_q, set_min_d;
  logic [FIELD_W-1:0] set_sec_q, set_sec_d;
  logic               load_q, load_d;
  logic               dec_q, dec_d;
  logic               alarm_q, alarm_d;
  logic               blink_min_q, blink_min_d;
  logic               blink_sec_q, blink_sec_d;
  logic               ph_q, ph_d;
  logic               bph_q, bph_d;
  logic [ACNT_W-1:0]  acnt_q, acnt_d;

  logic               act_clear, act_start, act_mode, act_up, act_down;
  logic               preset_zero;
  logic [FIELD_W-1:0] min_inc, min_dec, sec_inc, sec_dec;

  // One button action per cycle: clear > start > mode > up > down.
  assign act_clear = btn_clear;
  assign act_start = !btn_clear && btn_start;
  assign act_mode  = !btn_clear && !btn_start && btn_mode;
  assign act_up    = !btn_clear && !btn_start && !btn_mode && btn_up;
  assign act_down  = !btn_clear && !btn_start && !btn_mode && !btn_up && btn_down;

  assign preset_zero = (set_min_q == '0) && (set_sec_q == '0);

  assign min_inc = (set_min_q == MIN_TOP) ? '0 : set_min_q + FIELD_W'(1);
  assign min_dec = (set_min_q == '0) ? MIN_TOP : set_min_q - FIELD_W'(1);
  assign sec_inc = (set_sec_q == SEC_TOP) ? '0 : set_sec_q + FIELD_W'(1);
  assign sec_dec = (set_sec_q == '0) ? SEC_TOP : set_sec_q - FIELD_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      set_min_q   <= '0;
      set_sec_q   <= '0;
      load_q      <= 1'b0;
      dec_q       <= 1'b0;
      alarm_q     <= 1'b0;
      blink_min_q <= 1'b0;
      blink_sec_q <= 1'b0;
      ph_q        <= 1'b0;
      bph_q       <= 1'b0;
      acnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      load_q      <= load_d;
      dec_q       <= dec_d;
      alarm_q     <= alarm_d;
      blink_min_q <= blink_min_d;
      blink_sec_q <= blink_sec_d;
      ph_q        <= ph_d;
      bph_q       <= bph_d;
      acnt_q      <= acnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_min_d = set_min_q;
    set_sec_d = set_sec_q;
    load_d    = 1'b0;
    dec_d     = 1'b0;
    ph_d      = ph_q;
    bph_d     = bph_q;
    acnt_d    = acnt_q;

    case (state_q)
      S_IDLE: begin
        if (act_start && !preset_zero) begin
          state_d = S_RUN;
          load_d  = 1'b1;
        end else if (act_mode) begin
          state_d = S_SET_MIN;
        end
      end

      S_SET_MIN, S_SET_SEC: begin
        if (tick_half) bph_d = ~bph_q;
        if (act_clear) begin
          set_min_d = '0;
          set_sec_d = '0;
        end else if (act_start) begin
          if (!preset_zero) begin
            state_d = S_RUN;
            load_d  = 1'b1;
          end
        end else if (act_mode) begin
          state_d = (state_q == S_SET_MIN) ? S_SET_SEC : S_IDLE;
        end else if (act_up || act_down) begin
          bph_d = 1'b0;
          if (state_q == S_SET_MIN) set_min_d = act_up ? min_inc : min_dec;
          else                      set_sec_d = act_up ? sec_inc : sec_dec;
        end
      end

      // cnt_zero is stale while the datapath is still taking the load.
      S_RUN: begin
        if (act_clear) begin
          state_d = S_IDLE;
          load_d  = 1'b1;
        end else if (act_start) begin
          state_d = S_PAUSE;
        end else if (cnt_zero && !load_q) begin
          state_d = S_ALARM;
        end else if (tick_half) begin
          ph_d  = ~ph_q;
          dec_d = ph_q && !cnt_zero;
        end
      end

      S_PAUSE: begin
        if (act_clear) begin
          state_d = S_IDLE;
          load_d  = 1'b1;
        end else if (act_start) begin
          state_d = S_RUN;
        end
      end

      S_ALARM: begin
        if (btn_clear || btn_start || btn_mode || (tick_half && acnt_q == ACNT_LAST)) begin
          state_d = S_IDLE;
          load_d  = 1'b1;
          acnt_d  = '0;
        end else if (tick_half) begin
          acnt_d = acnt_q + ACNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_d) ph_d = 1'b0;
    if (state_d != state_q) bph_d = 1'b0;

    alarm_d     = (state_d == S_ALARM);
    blink_min_d = (state_d == S_SET_MIN) && bph_d;
    blink_sec_d = (state_d == S_SET_SEC) && bph_d;
  end

  assign state     = state_q;
  assign set_min   = set_min_q;
  assign set_sec   = set_sec_q;
  assign load      = load_q;
  assign dec       = dec_q;
  assign alarm     = alarm_q;
  assign blink_min = blink_min_q;
  assign blink_sec = blink_sec_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: constant vector table, directed multi-cycle sequences
// and random buttons/ticks against a behavioural model with a datapath stand-in.
module tb_timer_ctrl;

  localparam int unsigned MAX_MIN    = 59;
  localparam int unsigned ALARM_SECS = 2;

  localparam int ST_IDLE = 0, ST_SET_MIN = 1, ST_SET_SEC = 2, ST_RUN = 3, ST_PAUSE = 4, ST_ALARM = 5;
  localparam int A_NONE = 0, A_CLR = 1, A_START = 2, A_MODE = 3, A_UP = 4, A_DOWN = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down, btn_start, btn_clear, tick_half, cnt_zero;
  logic       load, dec, alarm, blink_min, blink_sec;
  logic [5:0] set_min, set_sec;
  logic [2:0] state;

  always #5 clock = ~clock;

  timer_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
    .clock(clock), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .btn_clear(btn_clear),
    .tick_half(tick_half), .cnt_zero(cnt_zero),
    .load(load), .set_min(set_min), .set_sec(set_sec), .dec(dec),
    .alarm(alarm), .blink_min(blink_min), .blink_sec(blink_sec), .state(state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: preset as plain integers, run/alarm progress as half-second counts.
  int m_state, m_min, m_sec, run_halves, alarm_halves, dp_secs;
  bit m_load, m_dec, m_bph;

  typedef struct {
    bit clr, st, md, up, dn, tk;
    int e_st, e_min, e_sec;
    bit e_ld, e_bm, e_bs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input bit clr, st, md, up, dn, tk,
                               input int e_st, e_min, e_sec, input bit e_ld, e_bm, e_bs);
    vec_t r;
    r.clr = clr; r.st = st; r.md = md; r.up = up; r.dn = dn; r.tk = tk;
    r.e_st = e_st; r.e_min = e_min; r.e_sec = e_sec;
    r.e_ld = e_ld; r.e_bm = e_bm; r.e_bs = e_bs;
    return r;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {state, set_min, set_sec, load, dec, alarm, blink_min, blink_sec};
  endfunction

  function automatic logic [19:0] model_vec();
    return {3'(m_state), 6'(m_min), 6'(m_sec), m_load, m_dec, (m_state == ST_ALARM),
            (m_state == ST_SET_MIN) && m_bph, (m_state == ST_SET_SEC) && m_bph};
  endfunction

  function automatic string fmt(input logic [19:0] v);
    return $sformatf("st=%0d min=%0d sec=%0d ld=%b dec=%b al=%b bm=%b bs=%b",
                     v[19:17], v[16:11], v[10:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  task automatic check_vec(input string name, input logic [19:0] exp);
    logic [19:0] got;
    got = dut_vec();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_min = 0; m_sec = 0; run_halves = 0; alarm_halves = 0;
    m_load = 0; m_dec = 0; m_bph = 0; dp_secs = 0;
  endtask

  task automatic model_step(input bit clr, st, md, up, dn, tk, cz);
    int act, nxt;
    bit ld, dc;
    act = clr ? A_CLR : st ? A_START : md ? A_MODE : up ? A_UP : dn ? A_DOWN : A_NONE;
    nxt = m_state; ld = 0; dc = 0;
    case (m_state)
      ST_IDLE, ST_SET_MIN, ST_SET_SEC: begin
        if (m_state != ST_IDLE && tk) m_bph = !m_bph;
        if (act == A_START && (m_min + m_sec) != 0) begin
          nxt = ST_RUN; ld = 1;
        end else if (act == A_MODE) begin
          nxt = (m_state == ST_IDLE) ? ST_SET_MIN : (m_state == ST_SET_MIN) ? ST_SET_SEC : ST_IDLE;
        end else if (m_state != ST_IDLE) begin
          if (act == A_CLR) begin
            m_min = 0; m_sec = 0;
          end else if (act == A_UP || act == A_DOWN) begin
            m_bph = 0;
            if (m_state == ST_SET_MIN)
              m_min = (m_min + ((act == A_UP) ? 1 : int'(MAX_MIN))) % (int'(MAX_MIN) + 1);
            else
              m_sec = (m_sec + ((act == A_UP) ? 1 : 59)) % 60;
          end
        end
      end
      ST_RUN: begin
        if (act == A_CLR) begin
          nxt = ST_IDLE; ld = 1;
        end else if (act == A_START) begin
          nxt = ST_PAUSE;
        end else if (cz && !m_load) begin
          nxt = ST_ALARM;
        end else if (tk) begin
          run_halves++;
          dc = (run_halves % 2 == 0) && !cz;
        end
      end
      ST_PAUSE: begin
        if (act == A_CLR) begin
          nxt = ST_IDLE; ld = 1;
        end else if (act == A_START) begin
          nxt = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (act == A_CLR || act == A_START || act == A_MODE) begin
          nxt = ST_IDLE; ld = 1;
        end else if (tk) begin
          alarm_halves++;
          if (alarm_halves >= 2 * int'(ALARM_SECS)) begin
            nxt = ST_IDLE; ld = 1;
          end
        end
      end
      default: nxt = ST_IDLE;
    endcase
    if (ld) begin run_halves = 0; alarm_halves = 0; end
    if (nxt != m_state) m_bph = 0;
    m_state = nxt; m_load = ld; m_dec = dc;
  endtask

  // One clock cycle: drive at negedge, advance model and datapath stand-in, compare at next negedge.
  task automatic step(input bit clr, st, md, up, dn, tk);
    bit cz;
    cz = (dp_secs == 0);
    btn_clear = clr; btn_start = st; btn_mode = md; btn_up = up; btn_down = dn;
    tick_half = tk; cnt_zero = cz;
    @(posedge clock);
    if (m_load) dp_secs = m_min * 60 + m_sec;
    else if (m_dec && dp_secs > 0) dp_secs--;
    model_step(clr, st, md, up, dn, tk, cz);
    @(negedge clock);
    cyc++;
    check_vec($sformatf("model@%0d", cyc), model_vec());
  endtask

  task automatic quiet_inputs();
    btn_clear = 0; btn_start = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    tick_half = 0; cnt_zero = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_vec("reset_values", 20'd0);
    reset = 1'b0;

    // Editing table: fields, wraps, blink phase, priority, zero-preset start.
    tbl.push_back(row(0,0,1,0,0,0, 1, 0, 0, 0,0,0));
    tbl.push_back(row(0,0,0,1,0,0, 1, 1, 0, 0,0,0));
    tbl.push_back(row(0,0,0,1,0,0, 1, 2, 0, 0,0,0));
    tbl.push_back(row(0,0,0,1,0,0, 1, 3, 0, 0,0,0));
    tbl.push_back(row(0,0,1,0,0,0, 2, 3, 0, 0,0,0));
    tbl.push_back(row(0,0,0,0,1,0, 2, 3,59, 0,0,0));
    tbl.push_back(row(0,0,0,0,0,1, 2, 3,59, 0,0,1));
    tbl.push_back(row(0,0,0,0,0,1, 2, 3,59, 0,0,0));
    tbl.push_back(row(0,0,0,0,0,1, 2, 3,59, 0,0,1));
    tbl.push_back(row(0,0,0,1,0,0, 2, 3, 0, 0,0,0));
    tbl.push_back(row(0,0,0,0,1,0, 2, 3,59, 0,0,0));
    tbl.push_back(row(0,0,1,0,0,0, 0, 3,59, 0,0,0));
    tbl.push_back(row(0,0,1,0,0,0, 1, 3,59, 0,0,0));
    tbl.push_back(row(1,0,0,0,0,0, 1, 0, 0, 0,0,0));
    tbl.push_back(row(0,0,0,0,1,0, 1,59, 0, 0,0,0));
    tbl.push_back(row(0,0,0,1,0,0, 1, 0, 0, 0,0,0));
    tbl.push_back(row(0,0,0,0,0,1, 1, 0, 0, 0,1,0));
    tbl.push_back(row(0,0,1,1,0,0, 2, 0, 0, 0,0,0));
    tbl.push_back(row(0,1,0,0,0,0, 2, 0, 0, 0,0,0));
    tbl.push_back(row(0,0,1,0,0,0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(0,1,0,0,0,0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(1,1,1,0,0,0, 0, 0, 0, 0,0,0));
    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].st, tbl[i].md, tbl[i].up, tbl[i].dn, tbl[i].tk);
      check_vec($sformatf("tbl[%0d]", i),
                {3'(tbl[i].e_st), 6'(tbl[i].e_min), 6'(tbl[i].e_sec), tbl[i].e_ld,
                 1'b0, 1'b0, tbl[i].e_bm, tbl[i].e_bs});
    end

    // Preset 0:02, run to zero, alarm times out after 2*ALARM_SECS ticks.
    step(0,0,1,0,0,0); step(0,0,1,0,0,0); step(0,0,0,1,0,0); step(0,0,0,1,0,0); step(0,0,1,0,0,0);
    check_val("preset_sec", 32'(set_sec), 2);
    step(0,1,0,0,0,0);
    check_val("start_load", 32'(load), 1);
    check_val("start_state", 32'(state), ST_RUN);
    step(0,0,0,0,0,1);
    check_val("load_one_cycle", 32'(load), 0);
    check_val("no_dec_first_tick", 32'(dec), 0);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,1);
    check_val("dec_second_tick", 32'(dec), 1);
    step(0,0,0,0,0,0);
    check_val("dec_one_wide", 32'(dec), 0);
    step(0,0,0,0,0,1); step(0,0,0,0,0,1);
    check_val("dec_second_sec", 32'(dec), 1);
    step(0,0,0,0,0,0);
    check_val("still_run", 32'(state), ST_RUN);
    step(0,0,0,0,0,0);
    check_val("alarm_state", 32'(state), ST_ALARM);
    check_val("alarm_out", 32'(alarm), 1);
    for (int k = 0; k < 3; k++) begin
      step(0,0,0,0,0,1);
      check_val("alarm_hold", 32'(state), ST_ALARM);
      check_val("alarm_no_dec", 32'(dec), 0);
    end
    step(0,0,0,0,0,1);
    check_val("alarm_timeout_state", 32'(state), ST_IDLE);
    check_val("alarm_timeout_load", 32'(load), 1);

    // Pause preserves the half-second phase; clear beats start.
    step(0,1,0,0,0,0);
    step(0,0,0,0,0,1);
    step(0,1,0,0,0,0);
    check_val("pause_state", 32'(state), ST_PAUSE);
    for (int k = 0; k < 6; k++) begin
      step(0,0,0,0,0,1);
      check_val("pause_no_dec", 32'(dec), 0);
    end
    step(0,1,0,0,0,0);
    check_val("resume_state", 32'(state), ST_RUN);
    check_val("resume_no_load", 32'(load), 0);
    step(0,0,0,0,0,1);
    check_val("resume_dec", 32'(dec), 1);
    step(1,1,0,0,0,0);
    check_val("clear_wins_state", 32'(state), ST_IDLE);
    check_val("clear_wins_load", 32'(load), 1);

    // Asynchronous reset in the middle of a run.
    step(0,1,0,0,0,0);
    step(0,0,0,0,0,1);
    step(0,0,0,0,0,0);
    #2 reset = 1'b1;
    #1 check_vec("async_reset", 20'd0);
    quiet_inputs();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    step(0,0,0,0,0,0);

    // Random buttons and ticks against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
